// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider with valid/ready handshakes on both sides.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with dividend/divisor in;
// out_valid/out_ready with quotient/remainder/div_by_zero/overflow out.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating quotient,
// remainder follows dividend sign); otherwise unsigned with overflow tied to 0.
module seq_divider #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] rem, quo, dvs, dd_in, dv_in, q_fin, r_fin;
  logic [WIDTH:0] sh, diff;
  logic [CW-1:0] cnt;
  logic accept, zero, last;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign zero = divisor == '0;
  assign last = cnt == CW'(WIDTH - 1);
  // Trial subtraction on the WIDTH+1-bit shifted partial remainder; MSB set means negative.
  assign sh = {rem, quo[WIDTH-1]};
  assign diff = sh - {1'b0, dvs};
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q, neg_r, ovf;
  assign dd_in = dividend[WIDTH-1] ? -dividend : dividend;
  assign dv_in = divisor[WIDTH-1] ? -divisor : divisor;
  assign q_fin = neg_q ? -quo : quo;
  assign r_fin = neg_r ? -rem : rem;
  // MIN/-1 needs no special datapath: |MIN| as unsigned is MIN, and negating it stays MIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ovf <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
      ovf <= dividend == {1'b1, {(WIDTH-1){1'b0}}} && divisor == '1;
      overflow <= 1'b0;
    end else if (state == FINISH) begin
      overflow <= ovf;
    end
  end
`else
  assign dd_in = dividend;
  assign dv_in = divisor;
  assign q_fin = quo;
  assign r_fin = rem;
  assign overflow = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = accept ? (zero ? DONE : CALC) : IDLE;
      CALC:    state_nx = last ? FINISH : CALC;
      FINISH:  state_nx = DONE;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_by_zero <= zero;
      if (zero) begin
        quotient <= '1;
        remainder <= dividend;
      end else begin
        quo <= dd_in;
        dvs <= dv_in;
        rem <= '0;
        cnt <= '0;
      end
    end else if (state == CALC) begin
      rem <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
      cnt <= cnt + 1'b1;
    end else if (state == FINISH) begin
      quotient <= q_fin;
      remainder <= r_fin;
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider at WIDTH=12.
module tb_seq_divider;
  localparam int W = 12;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, div_by_zero, overflow, ir_seen;
  logic [W-1:0] dividend = '0, divisor = '0, quotient, remainder;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Latency counts edges starting with the accept edge itself.
  task automatic op(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic [W-1:0] eq,
                    input logic [W-1:0] er, input logic edbz, input logic eovf,
                    input int elat, input int hold);
    int lat;
    @(negedge clk);
    dividend = dd;
    divisor = dv;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    ir_seen = 1'b0;
    #1 in_valid = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      ir_seen |= in_ready;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, elat);
    check("ready_low", 32'(ir_seen), 0);
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(edbz));
    check("overflow", 32'(overflow), 32'(eovf));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 1);
      check("hold_q", 32'(quotient), 32'(eq));
      check("hold_r", 32'(remainder), 32'(er));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 1);
    check("idle_valid", 32'(out_valid), 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_q", 32'(quotient), 0);
    check("rst_r", 32'(remainder), 0);
    check("rst_dbz", 32'(div_by_zero), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 1);
    op(12'd100, 12'd7, 12'd14, 12'd2, 1'b0, 1'b0, 14, 0);
    op(12'd5, 12'd0, 12'hFFF, 12'd5, 1'b1, 1'b0, 1, 0);
    op(12'd4095, 12'd1, 12'hFFF, 12'd0, 1'b0, 1'b0, 14, 5);
    op(12'd7, 12'd9, 12'd0, 12'd7, 1'b0, 1'b0, 14, 0);
    op(12'd1000, 12'd33, 12'd30, 12'd10, 1'b0, 1'b0, 14, 0);
    op(12'hFFF, 12'hFFF, 12'd1, 12'd0, 1'b0, 1'b0, 14, 0);
`ifdef SEQ_DIVIDER_SIGNED_EN
    op(12'hFF9, 12'd2, 12'hFFD, 12'hFFF, 1'b0, 1'b0, 14, 0);
    op(12'hFF9, 12'hFFE, 12'd3, 12'hFFF, 1'b0, 1'b0, 14, 0);
    op(12'd7, 12'hFFE, 12'hFFD, 12'd1, 1'b0, 1'b0, 14, 0);
    op(12'h800, 12'hFFF, 12'h800, 12'd0, 1'b0, 1'b1, 14, 0);
    op(12'hFF9, 12'd0, 12'hFFF, 12'hFF9, 1'b1, 1'b0, 1, 0);
`else
    op(12'd2048, 12'd3, 12'd682, 12'd2, 1'b0, 1'b0, 14, 0);
    op(12'h800, 12'hFFF, 12'd0, 12'h800, 1'b0, 1'b0, 14, 0);
`endif
    @(negedge clk);
    dividend = 12'd100;
    divisor = 12'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("calc_busy", 32'(in_ready), 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(out_valid), 0);
    check("abort_q", 32'(quotient), 0);
    check("abort_r", 32'(remainder), 0);
    check("abort_dbz", 32'(div_by_zero), 0);
    check("abort_ovf", 32'(overflow), 0);
    check("abort_ready", 32'(in_ready), 1);
    op(12'd9, 12'd3, 12'd3, 12'd0, 1'b0, 1'b0, 14, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 12, operand/result bit width (legal range 4..32).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operands presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port dividend  input  WIDTH  numerator, sampled on accept.
REQ-007 SHALL have port divisor  input  WIDTH  denominator, sampled on accept.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port quotient  output  WIDTH  result quotient.
REQ-011 SHALL have port remainder  output  WIDTH  result remainder.
REQ-012 SHALL have port div_by_zero  output  1  result came from divisor==0.
REQ-013 SHALL have port overflow  output  1  signed MIN/-1 result; constant 0 when signed mode compiled out.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FINISH, DONE.
REQ-015 SHALL assert in_ready only in IDLE; accept = in_valid && in_ready on a rising edge.
REQ-016 SHALL, on accept with divisor!=0, latch operands (magnitudes in signed mode), clear partial remainder, clear step counter, go to CALC.
REQ-017 SHALL perform one restoring step per cycle in CALC: shift {rem,quot} left by 1, trial-subtract divisor from WIDTH+1-bit partial remainder, keep on non-negative, set quotient LSB accordingly.
REQ-018 SHALL leave CALC after exactly WIDTH steps into FINISH, which registers quotient/remainder (sign-corrected in signed mode), then enters DONE with out_valid=1.
REQ-019 SHALL give latency of WIDTH+2 rising edges from accept edge to first cycle out_valid is high (divisor!=0).
REQ-020 SHALL, on accept with divisor==0, go directly to DONE next edge with quotient=all ones, remainder=dividend, div_by_zero=1.
REQ-021 SHALL hold out_valid, quotient, remainder, div_by_zero, overflow stable in DONE until out_ready=1.
REQ-022 SHALL, in DONE with out_ready=1, return to IDLE next edge and drop out_valid; no accept in the same cycle.
REQ-023 SHALL ignore in_valid and operand changes outside IDLE.
REQ-024 SHALL satisfy dividend = quotient*divisor + remainder, 0 <= remainder < divisor (unsigned mode).

Reset
REQ-025 SHALL, when rst=1 on an edge, enter IDLE from any state, discarding any in-flight operation.
REQ-026 SHALL reset out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0; in_ready=1 from the first cycle after reset.
REQ-027 SHALL give rst priority over accept and out_ready in the same cycle.

Configuration
REQ-028 SHALL use macro SEQ_DIVIDER_SIGNED_EN to select operand interpretation.
REQ-029 SHALL, with SEQ_DIVIDER_SIGNED_EN defined, treat operands as two's complement: quotient truncates toward zero, remainder takes dividend sign, magnitudes divided in CALC, negation applied in FINISH.
REQ-030 SHALL, with SEQ_DIVIDER_SIGNED_EN defined, return quotient=MIN, remainder=0, overflow=1 for dividend=MIN, divisor=-1, with normal latency.
REQ-031 SHALL, with SEQ_DIVIDER_SIGNED_EN defined, return quotient=all ones (-1), remainder=dividend, div_by_zero=1 for divisor 0.
REQ-032 SHALL, without SEQ_DIVIDER_SIGNED_EN, be unsigned only, overflow tied to 0, no sign logic present.

Verification (WIDTH=12)
REQ-033 SHALL check unsigned 100/7 -> quotient=14, remainder=2, out_valid first high 14 edges after accept, in_ready low throughout.
REQ-034 SHALL check 5/0 -> out_valid one edge after accept, quotient=0xFFF, remainder=5, div_by_zero=1.
REQ-035 SHALL check 4095/1 with out_ready held low 5 cycles in DONE -> quotient=0xFFF, remainder=0 stable all 5 cycles; IDLE one edge after out_ready=1.
REQ-036 SHALL check signed build -7/2 -> quotient=0xFFD, remainder=0xFFF; 0x800/0xFFF -> quotient=0x800, remainder=0, overflow=1.
REQ-037 SHALL check rst=1 at CALC step 6 of 100/7 -> all outputs 0, in_ready=1 next cycle; following 9/3 -> quotient=3, remainder=0, no residue from aborted operation.
